// File: rtl/conv_event_fifo.sv
// conv_event_fifo: circular event buffer feeding Convolution2d over a valid/ack handshake.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready   source handshake; in_ready = !full
//   in_timestep, in_x,    incoming spike event fields
//   in_y, in_spikes
//   event_out             registered {timestep, x, y, spikes} of the presented event
//   event_valid / event_ack  consumer handshake; one pop per ack assertion
//   count, full, empty    registered occupancy
//   drop_count            saturating count of filtered events
//
// Build option: define CONV_EVENT_FIFO_FILTER_EN to drop events with an empty
// spike mask or out-of-image coordinates instead of storing them.
module conv_event_fifo #(
    parameter int COORD_BITS  = 8,
    parameter int IN_CHANNELS = 2,
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8,
    parameter int DEPTH       = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  in_timestep,
    input  logic [COORD_BITS-1:0]                 in_x,
    input  logic [COORD_BITS-1:0]                 in_y,
    input  logic [IN_CHANNELS-1:0]                in_spikes,
    output logic [1+2*COORD_BITS+IN_CHANNELS-1:0] event_out,
    output logic                                  event_valid,
    input  logic                                  event_ack,
    output logic [$clog2(DEPTH):0]                count,
    output logic                                  full,
    output logic                                  empty,
    output logic [15:0]                           drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 1 + 2 * COORD_BITS + IN_CHANNELS;

    typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_WAIT_ACK_LOW} state_t;

    state_t          r_state, w_state_nxt;
    logic [EW-1:0]   r_mem [DEPTH];
    logic [EW-1:0]   r_event_out;
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count, w_count_nxt;
    logic            r_full, r_empty;
    logic [15:0]     r_drop;
    logic            w_push, w_store, w_pop, w_load, w_bad, w_filter;

    assign in_ready   = !r_full;
    assign w_push     = in_valid && in_ready;
    assign w_bad      = (in_spikes == '0) || (32'(in_x) >= IMG_WIDTH) || (32'(in_y) >= IMG_HEIGHT);
`ifdef CONV_EVENT_FIFO_FILTER_EN
    assign w_filter   = w_bad;
`else
    assign w_filter   = 1'b0 && w_bad;
`endif
    assign w_store     = w_push && !w_filter;
    assign w_pop       = (r_state == S_PRESENT) && event_ack;
    assign w_load      = (r_state == S_IDLE) && !r_empty;
    assign w_count_nxt = r_count + CW'(w_store) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_store) r_mem[r_wr_ptr] <= {in_timestep, in_x, in_y, in_spikes};
    end

    // Pointer width equals log2(DEPTH), so increments wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_drop      <= '0;
            r_event_out <= '0;
        end else begin
            if (w_store) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= w_count_nxt == CW'(DEPTH);
            r_empty <= w_count_nxt == '0;
            if (w_push && w_filter && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
            if (w_load) r_event_out <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else r_state <= w_state_nxt;
    end

    // WAIT_ACK_LOW guarantees a held ack pops only once.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:         w_state_nxt = r_empty ? S_IDLE : S_PRESENT;
            S_PRESENT:      w_state_nxt = event_ack ? S_WAIT_ACK_LOW : S_PRESENT;
            S_WAIT_ACK_LOW: w_state_nxt = event_ack ? S_WAIT_ACK_LOW : S_IDLE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        event_valid = r_state == S_PRESENT;
        event_out   = r_event_out;
        count       = r_count;
        full        = r_full;
        empty       = r_empty;
        drop_count  = r_drop;
    end
endmodule

// File: tb/tb_conv_event_fifo.sv
// tb_conv_event_fifo: directed plus random stimulus against a queue-based event model.
module tb_conv_event_fifo;
    localparam int CB = 8, IC = 2, W = 8, H = 8, D = 16;
    localparam int EW = 1 + 2 * CB + IC;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0, rst = 1'b1;
    logic          in_valid = 1'b0, in_ready, in_timestep = 1'b0;
    logic [CB-1:0] in_x = '0, in_y = '0;
    logic [IC-1:0] in_spikes = '0;
    logic [EW-1:0] event_out;
    logic          event_valid, event_ack = 1'b0, full, empty;
    logic [CW-1:0] count;
    logic [15:0]   drop_count;

    conv_event_fifo #(.COORD_BITS(CB), .IN_CHANNELS(IC), .IMG_WIDTH(W), .IMG_HEIGHT(H), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_timestep(in_timestep),
        .in_x(in_x), .in_y(in_y), .in_spikes(in_spikes), .event_out(event_out),
        .event_valid(event_valid), .event_ack(event_ack), .count(count), .full(full),
        .empty(empty), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    // Model: stored events in a queue; m_pres = an event is on offer,
    // m_hold = consumed, waiting for the consumer to drop ack.
    logic [EW-1:0] q[$];
    logic          m_pres = 1'b0, m_hold = 1'b0;
    logic [EW-1:0] m_out = '0;
    int            m_drop = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] mk(input int ts, input int x, input int y, input int sp);
        return {ts[0], CB'(x), CB'(y), IC'(sp)};
    endfunction

    function automatic logic is_bad(input logic [EW-1:0] e);
        return e[IC-1:0] == '0 || int'(e[IC+2*CB-1:IC+CB]) >= W || int'(e[IC+CB-1:IC]) >= H;
    endfunction

    task automatic check_all();
        chk("event_valid", 64'(event_valid), 64'(m_pres));
        chk("event_out", 64'(event_out), 64'(m_out));
        chk("count", 64'(count), 64'(q.size()));
        chk("full", 64'(full), 64'(q.size() == D));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() != D));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
    endtask

    task automatic model_edge();
        logic [EW-1:0] ev;
        logic          push, filt;
        ev   = {in_timestep, in_x, in_y, in_spikes};
        push = in_valid && q.size() < D;
`ifdef CONV_EVENT_FIFO_FILTER_EN
        filt = is_bad(ev);
`else
        filt = 1'b0;
`endif
        if (m_pres && event_ack) begin
            void'(q.pop_front());
            m_pres = 1'b0;
            m_hold = 1'b1;
        end else if (m_hold && !event_ack) begin
            m_hold = 1'b0;
        end else if (!m_pres && !m_hold && q.size() > 0) begin
            m_out  = q[0];
            m_pres = 1'b1;
        end
        if (push && filt) m_drop = (m_drop == 65535) ? m_drop : m_drop + 1;
        else if (push) q.push_back(ev);
    endtask

    task automatic cyc(input logic v, input logic [EW-1:0] ev, input logic a);
        in_valid = v;
        {in_timestep, in_x, in_y, in_spikes} = ev;
        event_ack = a;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n, input logic a);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, a);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) cyc(1'b0, '0, logic'(i % 2));
    endtask

    task automatic async_reset();
        in_valid  = 1'b0;
        event_ack = 1'b0;
        #2 rst = 1'b1;
        q.delete();
        m_pres = 1'b0;
        m_hold = 1'b0;
        m_out  = '0;
        m_drop = 0;
        #1 check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;
        // single event
        cyc(1'b1, mk(0, 5, 3, 3), 1'b0);
        idle(3, 1'b0);
        cyc(1'b0, '0, 1'b1);
        idle(3, 1'b0);
        // burst to full, 17th held until space frees, then drain across wrap
        for (int i = 0; i < 17; i++) cyc(1'b1, mk(i, i % 8, (i * 3) % 8, 1 + i % 3), 1'b0);
        cyc(1'b1, mk(16, 0, 0, 3), 1'b0);
        cyc(1'b1, mk(16, 0, 0, 3), 1'b1);
        cyc(1'b1, mk(16, 0, 0, 3), 1'b0);
        drain();
        // held ack with 3 entries
        for (int i = 0; i < 3; i++) cyc(1'b1, mk(1, i, 7 - i, 2), 1'b0);
        idle(2, 1'b0);
        idle(5, 1'b1);
        idle(4, 1'b0);
        drain();
        // simultaneous push and pop at count 4
        for (int i = 0; i < 4; i++) cyc(1'b1, mk(0, 4 + i, i, 1), 1'b0);
        idle(2, 1'b0);
        cyc(1'b1, mk(1, 7, 7, 3), 1'b1);
        drain();
        // filter candidates
        cyc(1'b1, mk(0, 1, 1, 0), 1'b0);
        cyc(1'b1, mk(0, 8, 1, 1), 1'b0);
        cyc(1'b1, mk(0, 1, 9, 1), 1'b0);
        cyc(1'b1, mk(0, 0, 5, 2), 1'b0);
        drain();
        // asynchronous reset while presenting with 5 entries
        for (int i = 0; i < 5; i++) cyc(1'b1, mk(1, i, i, 1), 1'b0);
        idle(2, 1'b0);
        async_reset();
        cyc(1'b1, mk(1, 6, 2, 1), 1'b0);
        idle(3, 1'b0);
        cyc(1'b0, '0, 1'b1);
        idle(2, 1'b0);
        // random traffic
        for (int i = 0; i < 3000; i++)
            cyc(logic'($urandom_range(0, 9) < 6),
                mk($urandom, $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 3)),
                logic'($urandom_range(0, 2) == 0));
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/conv_event_fifo.md
# conv_event_fifo

Input event buffer directly upstream of the `Convolution2d` stage. Accepts spike events (timestep, x, y, per-channel spike mask) from the event source with a ready/valid handshake, stores them in a circular FIFO and presents them one at a time on the valid/ack handshake that `Convolution2d` consumes on `event_in`/`event_valid`/`event_ack`. The FIFO absorbs event bursts while the convolution is busy with the membrane-potential read-modify-write cycle behind the arbiter.

## Interface

**Parameters**
- `COORD_BITS`, default 8: width of each x/y coordinate.
- `IN_CHANNELS`, default 2: spike mask width.
- `IMG_WIDTH`, default 8: valid x range is 0..IMG_WIDTH-1.
- `IMG_HEIGHT`, default 8: valid y range is 0..IMG_HEIGHT-1.
- `DEPTH`, default 16: FIFO entries; power of two, at least 2.

**Ports**
- `clk`, in, 1: clock; all logic on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `in_valid`, in, 1: source event valid.
- `in_ready`, out, 1: FIFO can accept; equals `!full`.
- `in_timestep`, in, 1: timestep bit.
- `in_x`, in, COORD_BITS: column.
- `in_y`, in, COORD_BITS: row.
- `in_spikes`, in, IN_CHANNELS: spike mask.
- `event_out`, out, 1+2·COORD_BITS+IN_CHANNELS: packed {timestep, x, y, spikes}, same layout as `input_vector_t`.
- `event_valid`, out, 1: `event_out` is valid.
- `event_ack`, in, 1: consumer acknowledge.
- `count`, out, $clog2(DEPTH)+1: stored entries.
- `full`, out, 1: `count == DEPTH`.
- `empty`, out, 1: `count == 0`.
- `drop_count`, out, 16: number of filtered events, saturating.

## Operation

- **Push.** A push happens when `in_valid && in_ready`. The event is written at `wr_ptr`, then `wr_ptr` increments modulo DEPTH. The FIFO is a register array: no reset of its contents, pointers reset to 0.
- **Output FSM states.** IDLE, PRESENT, WAIT_ACK_LOW.
  - **IDLE.** If `!empty`: load the head entry into the `event_out` register, assert `event_valid`, and go to PRESENT.
  - **PRESENT.** Hold `event_out` and `event_valid=1` until `event_ack=1`. On that cycle: pop (increment `rd_ptr` modulo DEPTH, decrement `count`), clear `event_valid`, and go to WAIT_ACK_LOW.
  - **WAIT_ACK_LOW.** Stay until `event_ack=0`, then go to IDLE. Holding `event_ack` for several cycles must never cause more than one pop.
- **Ack outside PRESENT.** `event_ack` is ignored in IDLE.
- **Count update.** `count` takes push and pop together. A simultaneous push and pop leaves `count` unchanged.
- **Full.** `in_ready=0`. A held `in_valid` is neither lost nor counted; it is accepted on the first cycle after a pop frees space.
- **Wrap-around.** Pointers wrap from DEPTH-1 to 0. The `count` width distinguishes full from empty.
- **Reset mid-operation.** All state clears immediately: pointers=0, `count=0`, `event_valid=0`, `event_out=0`, `drop_count=0`, FSM returns to IDLE. Stored events are discarded.

## Timing

- **Reset values.** `in_ready=1`, `event_valid=0`, `event_out=0`, `count=0`, `full=0`, `empty=1`, `drop_count=0`.
- **Push to output latency.** A push into an empty FIFO in cycle N gives `count=1` at N+1 and `event_valid=1` at N+2.
- **Ack to pop.** An ack in cycle M pops at the M edge. `event_valid=0` from M+1.
- **Back-to-back events.** The next `event_valid` rises no earlier than 2 cycles after `event_ack` falls: one cycle in WAIT_ACK_LOW seeing ack low, then one cycle in IDLE loading.
- **Outputs.** `full`, `empty` and `count` are registered. `in_ready` is combinational from `full`.

## Configuration

- **`CONV_EVENT_FIFO_FILTER_EN` defined.** An event with `in_spikes == 0`, `in_x >= IMG_WIDTH`, or `in_y >= IMG_HEIGHT` is acknowledged (`in_ready` as normal) but not written. `drop_count` increments, saturating at 16'hFFFF.
- **`CONV_EVENT_FIFO_FILTER_EN` undefined.** Every accepted event is stored, and `drop_count` stays 0.

## Test plan

1. **Single event.** After reset, push {0, x=5, y=3, spikes=2'b11}. `event_valid` rises 2 cycles later with `event_out` matching. Pulse `event_ack` for 1 cycle: `count` goes 1→0 and `event_valid` falls next cycle.
2. **Burst to full.** With `event_ack` held 0, push 17 events into DEPTH=16. After 16 pushes `full=1` and `in_ready=0`. The 17th is accepted only after the first ack. Events emerge in push order, including across pointer wrap.
3. **Held ack.** Hold `event_ack=1` for 5 cycles with 3 entries stored. Exactly one pop occurs (`count` 3→2), and the next `event_valid` appears only after ack falls.
4. **Simultaneous push and pop.** Push and ack in the same cycle with `count=4`: `count` stays 4 and the data order is preserved.
5. **Filter (macro defined).** Push spikes=0, x=8, y=9, then {0, 0, 5, 2'b10}. Only the last is presented, and `drop_count=3`. With the macro undefined, all 4 are presented and `drop_count=0`.
6. **Reset mid-operation.** Assert `rst` asynchronously while in PRESENT with 5 entries. Outputs immediately take their reset values, and a fresh push after reset is the first event presented.
